microondas_timer: RTL and testbench

- Cook-time countdown stage directly upstream of the magnetron controller.
- Takes keypad digits, holds a BCD mm:ss count and decrements it once per second while `ligar` is asserted.
- Drives `zero`, which the magnetron controller uses to shut off heating, and the four BCD digits for the display decoder.

---
 rtl/microondas_timer_if.sv | 32 +++
 rtl/microondas_timer.sv | 191 +++++++++++++++++++
 tb/tb_microondas_timer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/microondas_timer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : microondas_timer_if
//  Brief    : Keypad / magnetron / display bundle for the cook-time timer.
//             master = keypad + magnetron side, slave = timer.
//  Revision : 1.0 - initial release
// ============================================================================
interface microondas_timer_if;
    logic       clrn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       ligar;
    logic       key_add30;
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic       zero;
    logic       done;

    modport master (
        output clrn, key_valid, key_digit, ligar, key_add30,
        input  min_t, min_u, sec_t, sec_u, zero, done
    );

    modport slave (
        input  clrn, key_valid, key_digit, ligar, key_add30,
        output min_t, min_u, sec_t, sec_u, zero, done
    );
endinterface
`default_nettype wire

// File: rtl/microondas_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : microondas_timer
//  Brief    : BCD mm:ss cook-time countdown. Keypad digits shift in from the
//             right, the count decrements once per TICKS_PER_SEC cycles while
//             ligar is high, zero/done tell the magnetron controller to stop.
//             Optional "+30 s" key enabled by defining MICROONDAS_ADD30_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module microondas_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input  wire logic          clk,
    input  wire logic          clr,
    microondas_timer_if.slave  bus
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] C_TICK_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SET  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [15:0]    cnt_q,   cnt_d;     // {min_t, min_u, sec_t, sec_u}
    logic           zero_q;
    logic           done_q,  done_d;

    logic           w_key_ok;
    logic           w_tick;
    logic           w_add;

    // One-second BCD decrement; seconds 60-99 fall through linearly, 00:00 holds.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = c;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            su = 4'd9;
        end else if ({mt, mu} != 8'd0) begin
            if (mu != 4'd0) begin
                mu = mu - 4'd1;
            end else begin
                mt = mt - 4'd1;
                mu = 4'd9;
            end
            st = 4'd5;
            su = 4'd9;
        end
        return {mt, mu, st, su};
    endfunction

`ifdef MICROONDAS_ADD30_EN
    // Adds 30 s after folding any 60-99 seconds entry into minutes; clamps at 99:59.
    function automatic logic [15:0] bcd_add30(input logic [15:0] c);
        logic [7:0] mins, secs;
        mins = 8'(c[15:12]) * 8'd10 + 8'(c[11:8]);
        secs = 8'(c[7:4]) * 8'd10 + 8'(c[3:0]) + 8'd30;
        if (secs >= 8'd120) begin
            mins = mins + 8'd2;
            secs = secs - 8'd120;
        end else if (secs >= 8'd60) begin
            mins = mins + 8'd1;
            secs = secs - 8'd60;
        end
        if (mins > 8'd99) begin
            return 16'h9959;
        end
        return {4'(mins / 8'd10), 4'(mins % 8'd10), 4'(secs / 8'd10), 4'(secs % 8'd10)};
    endfunction

    assign w_add = bus.key_add30;
`else
    logic w_add30_unused;
    assign w_add30_unused = bus.key_add30;
    assign w_add = 1'b0;
`endif

    assign w_key_ok = bus.key_valid && !bus.ligar && (bus.key_digit <= 4'd9);
    assign w_tick   = bus.ligar && (presc_q == C_TICK_LAST);

    // Next-state and datapath: clear first, then per-state entry / countdown / +30.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (!bus.clrn) begin
            state_d = IDLE;
            presc_d = '0;
            cnt_d   = 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_key_ok) begin
                        cnt_d   = {cnt_q[11:0], bus.key_digit};
                        presc_d = '0;
                        if (bus.key_digit != 4'd0) begin
                            state_d = SET;
                        end
                    end
                    if (w_add) begin
                        cnt_d   = add30_or_pass(cnt_d);
                        state_d = SET;
                    end
                end
                SET: begin
                    if (bus.ligar) begin
                        state_d = RUN;
                    end else if (w_key_ok) begin
                        // A fresh entry restarts the second; shifting out every
                        // nonzero digit returns to IDLE.
                        cnt_d   = {cnt_q[11:0], bus.key_digit};
                        presc_d = '0;
                        if (cnt_d == 16'h0000) begin
                            state_d = IDLE;
                        end
                    end
                    if (w_add) begin
                        cnt_d = add30_or_pass(cnt_d);
                        if (cnt_d != 16'h0000 && state_d == IDLE) begin
                            state_d = SET;
                        end
                    end
                end
                RUN: begin
                    if (!bus.ligar) begin
                        state_d = SET;              // pause, prescaler held
                    end else if (w_tick) begin
                        presc_d = '0;
                        cnt_d   = bcd_dec(cnt_q);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (w_add) begin
                        cnt_d = add30_or_pass(cnt_d);
                    end
                    if (w_tick && cnt_d == 16'h0000) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        presc_d = '0;
                    end
                end
                default: begin                      // DONE
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Pass-through when the +30 key is compiled out keeps the FSM body identical.
    function automatic logic [15:0] add30_or_pass(input logic [15:0] c);
`ifdef MICROONDAS_ADD30_EN
        return bcd_add30(c);
`else
        return c;
`endif
    endfunction

    // State, count and registered zero/done outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            presc_q <= '0;
            cnt_q   <= 16'h0000;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            zero_q  <= (cnt_d == 16'h0000);
            done_q  <= done_d;
        end
    end

    assign bus.min_t = cnt_q[15:12];
    assign bus.min_u = cnt_q[11:8];
    assign bus.sec_t = cnt_q[7:4];
    assign bus.sec_u = cnt_q[3:0];
    assign bus.zero  = zero_q;
    assign bus.done  = done_q;
endmodule
`default_nettype wire

// File: tb/tb_microondas_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_microondas_timer
//  Brief    : Directed, table-driven bench for microondas_timer with
//             TICKS_PER_SEC = 4 (MICROONDAS_ADD30_EN selects the +30 checks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_microondas_timer;
    logic clk = 1'b0;
    logic clr;

    microondas_timer_if bus();

    microondas_timer #(.TICKS_PER_SEC(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clrn;
        logic        kv;
        logic [3:0]  kd;
        logic        lig;
        logic        add;
        logic [15:0] cnt;
        logic        z;
        logic        d;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic v(input logic clrn, input logic kv, input logic [3:0] kd,
                     input logic lig, input logic add,
                     input logic [15:0] cnt, input logic z, input logic d);
        vec_t r;
        r.clrn = clrn; r.kv = kv; r.kd = kd; r.lig = lig; r.add = add;
        r.cnt = cnt; r.z = z; r.d = d;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic clrn, input logic kv, input logic [3:0] kd,
                         input logic lig, input logic add);
        bus.clrn      = clrn;
        bus.key_valid = kv;
        bus.key_digit = kd;
        bus.ligar     = lig;
        bus.key_add30 = add;
    endtask

    // Drive for one cycle, then sample 1 ns after the rising edge.
    task automatic cyc(input logic clrn, input logic kv, input logic [3:0] kd,
                       input logic lig, input logic add);
        drive(clrn, kv, kd, lig, add);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] cnt,
                       input logic z, input logic d);
        logic [15:0] got;
        got = {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
        n_cmp++;
        if (got !== cnt || bus.zero !== z || bus.done !== d) begin
            n_err++;
            $display("FAIL %s: got %h zero=%b done=%b, expected %h zero=%b done=%b",
                     name, got, bus.zero, bus.done, cnt, z, d);
        end
    endtask

    initial begin
        clr = 1'b1;
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 16'h0000, 1'b1, 1'b0);
        clr = 1'b0;

        // clrn kv kd lig add | cnt z d
        // digit entry, invalid digit, clear priority, IDLE corner cases
        v(1,1,4'd1,0,0, 16'h0001,0,0);
        v(1,1,4'd3,0,0, 16'h0013,0,0);
        v(1,1,4'd0,0,0, 16'h0130,0,0);
        v(1,1,4'hA,0,0, 16'h0130,0,0);
        v(1,0,4'd0,0,0, 16'h0130,0,0);
        v(0,1,4'd5,0,0, 16'h0000,1,0);
        v(1,1,4'd0,0,0, 16'h0000,1,0);
        v(1,0,4'd0,1,0, 16'h0000,1,0);
        // 00:02 countdown to done
        v(1,1,4'd2,0,0, 16'h0002,0,0);
        v(1,0,4'd0,1,0, 16'h0002,0,0);
        v(1,0,4'd0,1,0, 16'h0002,0,0);
        v(1,0,4'd0,1,0, 16'h0002,0,0);
        v(1,0,4'd0,1,0, 16'h0002,0,0);
        v(1,0,4'd0,1,0, 16'h0001,0,0);
        v(1,0,4'd0,1,0, 16'h0001,0,0);
        v(1,0,4'd0,1,0, 16'h0001,0,0);
        v(1,0,4'd0,1,0, 16'h0001,0,0);
        v(1,0,4'd0,1,0, 16'h0000,1,1);
        v(1,0,4'd0,0,0, 16'h0000,1,0);
        v(1,0,4'd0,0,0, 16'h0000,1,0);
        // 01:00 -> 00:59
        v(1,1,4'd1,0,0, 16'h0001,0,0);
        v(1,1,4'd0,0,0, 16'h0010,0,0);
        v(1,1,4'd0,0,0, 16'h0100,0,0);
        v(1,0,4'd0,1,0, 16'h0100,0,0);
        v(1,0,4'd0,1,0, 16'h0100,0,0);
        v(1,0,4'd0,1,0, 16'h0100,0,0);
        v(1,0,4'd0,1,0, 16'h0100,0,0);
        v(1,0,4'd0,1,0, 16'h0059,0,0);
        v(0,0,4'd0,0,0, 16'h0000,1,0);
        // 00:90 -> 00:89
        v(1,1,4'd9,0,0, 16'h0009,0,0);
        v(1,1,4'd0,0,0, 16'h0090,0,0);
        v(1,0,4'd0,1,0, 16'h0090,0,0);
        v(1,0,4'd0,1,0, 16'h0090,0,0);
        v(1,0,4'd0,1,0, 16'h0090,0,0);
        v(1,0,4'd0,1,0, 16'h0090,0,0);
        v(1,0,4'd0,1,0, 16'h0089,0,0);
        v(0,0,4'd0,0,0, 16'h0000,1,0);
        // key ignored while running, clear coinciding with a tick
        v(1,1,4'd9,0,0, 16'h0009,0,0);
        v(1,0,4'd0,1,0, 16'h0009,0,0);
        v(1,0,4'd0,1,0, 16'h0009,0,0);
        v(1,1,4'd5,1,0, 16'h0009,0,0);
        v(1,0,4'd0,1,0, 16'h0009,0,0);
        v(0,0,4'd0,1,0, 16'h0000,1,0);
        v(1,0,4'd0,1,0, 16'h0000,1,0);
        v(1,0,4'd0,0,0, 16'h0000,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].clrn, vecs[i].kv, vecs[i].kd, vecs[i].lig, vecs[i].add);
            chk($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].z, vecs[i].d);
        end

        // Pause keeps the partial second; resume ticks after the remaining cycles.
        cyc(1, 1, 4'd5, 0, 0);
        chk("pause_load", 16'h0005, 1'b0, 1'b0);
        cyc(1, 0, 4'd0, 1, 0);
        repeat (6) cyc(1, 0, 4'd0, 1, 0);
        chk("pause_run6", 16'h0004, 1'b0, 1'b0);
        repeat (10) cyc(1, 0, 4'd0, 0, 0);
        chk("pause_frozen", 16'h0004, 1'b0, 1'b0);
        cyc(1, 0, 4'd0, 1, 0);
        cyc(1, 0, 4'd0, 1, 0);
        chk("resume_pre", 16'h0004, 1'b0, 1'b0);
        cyc(1, 0, 4'd0, 1, 0);
        chk("resume_tick", 16'h0003, 1'b0, 1'b0);
        cyc(0, 0, 4'd0, 0, 0);
        chk("pause_clear", 16'h0000, 1'b1, 1'b0);

`ifdef MICROONDAS_ADD30_EN
        cyc(1, 0, 4'd0, 0, 1);
        chk("add30_idle", 16'h0030, 1'b0, 1'b0);
        cyc(1, 0, 4'd0, 1, 0);
        repeat (4) cyc(1, 0, 4'd0, 1, 0);
        chk("add30_set_runs", 16'h0029, 1'b0, 1'b0);
        cyc(0, 0, 4'd0, 0, 0);
        cyc(1, 1, 4'd9, 0, 0);
        cyc(1, 1, 4'd9, 0, 0);
        cyc(1, 1, 4'd4, 0, 0);
        cyc(1, 1, 4'd5, 0, 0);
        cyc(1, 0, 4'd0, 0, 1);
        chk("add30_sat", 16'h9959, 1'b0, 1'b0);
        cyc(0, 0, 4'd0, 0, 0);
        cyc(1, 1, 4'd4, 0, 0);
        cyc(1, 1, 4'd5, 0, 0);
        cyc(1, 0, 4'd0, 0, 1);
        chk("add30_carry", 16'h0115, 1'b0, 1'b0);
        cyc(0, 0, 4'd0, 0, 0);
        cyc(1, 1, 4'd9, 0, 0);
        cyc(1, 1, 4'd0, 0, 0);
        cyc(1, 0, 4'd0, 0, 1);
        chk("add30_norm", 16'h0200, 1'b0, 1'b0);
        cyc(0, 0, 4'd0, 0, 1);
        chk("add30_clr_wins", 16'h0000, 1'b1, 1'b0);
`else
        cyc(1, 1, 4'd4, 0, 0);
        cyc(1, 1, 4'd5, 0, 0);
        cyc(1, 0, 4'd0, 0, 1);
        chk("add30_ignored", 16'h0045, 1'b0, 1'b0);
        cyc(0, 0, 4'd0, 0, 1);
        cyc(1, 0, 4'd0, 0, 1);
        chk("add30_idle_ignored", 16'h0000, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
